// File: rtl/demux_pkg.sv
// Shared constants and helpers for the demux_router block.
// Optional feature macro: DEMUX_ROUTER_COUNT_EN (per-destination pop counters).
package demux_pkg;

  localparam int WIDTH = 32;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  // Number of bits needed to index 'value' entries (value >= 2).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO used as the per-destination buffer of demux_router.
// Head word is forced to zero while empty; push when full and pop when empty
// are ignored so the caller cannot corrupt pointers.
module demux_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = demux_pkg::WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic do_push;
  logic do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux_router.sv
// demux_router: steers one word stream into two independently buffered outputs.
// Optional feature macro: DEMUX_ROUTER_COUNT_EN adds cnt0/cnt1 pop counters.
//
// Handshake rules (all ports): a transfer happens on the rising edge where
// valid & ready are both high. Producers hold valid/data until accepted;
// in_ready depends on in_sel and FIFO fullness only (never on the pops of the
// same cycle), and is low while reset is high.
module demux_router
  import demux_pkg::*;
#(
  parameter int WIDTH = demux_pkg::WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
`ifdef DEMUX_ROUTER_COUNT_EN
  output logic [WIDTH-1:0] out1_data,
  output logic [31:0]      cnt0,
  output logic [31:0]      cnt1
`else
  output logic [WIDTH-1:0] out1_data
`endif
);

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;
  logic pop0, pop1;
  logic accept;

  assign in_ready   = ~reset & ((in_sel == SEL_OUT1) ? ~full1 : ~full0);
  assign accept     = in_valid & in_ready;
  assign push0      = accept & (in_sel == SEL_OUT0);
  assign push1      = accept & (in_sel == SEL_OUT1);
  assign out0_valid = ~empty0;
  assign out1_valid = ~empty1;
  assign pop0       = out0_valid & out0_ready;
  assign pop1       = out1_valid & out1_ready;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push0),
    .push_data (in_data),
    .pop       (pop0),
    .full      (full0),
    .empty     (empty0),
    .head      (out0_data)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push1),
    .push_data (in_data),
    .pop       (pop1),
    .full      (full1),
    .empty     (empty1),
    .head      (out1_data)
  );

`ifdef DEMUX_ROUTER_COUNT_EN
  // Completed output handshakes per destination, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (pop0) cnt0 <= cnt0 + 32'd1;
      if (pop1) cnt1 <= cnt1 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_router.sv
// Bench for demux_router: directed scenarios plus randomized traffic, checked
// every cycle against a two-queue reference model.
// Optional feature macro: DEMUX_ROUTER_COUNT_EN (also checks cnt0/cnt1).
module tb_demux_router;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
`ifdef DEMUX_ROUTER_COUNT_EN
  logic [31:0]      cnt0;
  logic [31:0]      cnt1;
`endif

  demux_router #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
`ifdef DEMUX_ROUTER_COUNT_EN
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`else
    .out1_data  (out1_data)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state: expected contents of each destination buffer
  logic [WIDTH-1:0] exp_q0[$];
  logic [WIDTH-1:0] exp_q1[$];
  logic [WIDTH-1:0] rx1_q[$];
  int unsigned      m_cnt0;
  int unsigned      m_cnt1;
  bit               last_acc;

  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    if (reset) return 1'b0;
    if (in_sel) return exp_q1.size() < DEPTH;
    return exp_q0.size() < DEPTH;
  endfunction

  // One clock cycle: compare outputs with the model, then advance the model
  // by what the rising edge is going to do with the current inputs.
  task automatic step();
    bit acc, p0, p1;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(model_ready()));
    check("out0_valid", 32'(out0_valid), 32'(exp_q0.size() != 0));
    check("out0_data", out0_data, (exp_q0.size() != 0) ? exp_q0[0] : 32'h0);
    check("out1_valid", 32'(out1_valid), 32'(exp_q1.size() != 0));
    check("out1_data", out1_data, (exp_q1.size() != 0) ? exp_q1[0] : 32'h0);
`ifdef DEMUX_ROUTER_COUNT_EN
    check("cnt0", cnt0, m_cnt0);
    check("cnt1", cnt1, m_cnt1);
`endif
    last_acc = 1'b0;
    if (reset) begin
      exp_q0.delete();
      exp_q1.delete();
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else begin
      acc = in_valid && model_ready();
      p0  = out0_ready && (exp_q0.size() != 0);
      p1  = out1_ready && (exp_q1.size() != 0);
      if (p0) begin
        void'(exp_q0.pop_front());
        m_cnt0++;
      end
      if (p1) begin
        rx1_q.push_back(out1_data);
        void'(exp_q1.pop_front());
        m_cnt1++;
      end
      if (acc) begin
        if (in_sel) exp_q1.push_back(in_data);
        else        exp_q0.push_back(in_data);
      end
      last_acc = acc;
    end
    @(posedge clk);
    #1;
  endtask

  // Driver helpers
  task automatic drive(input bit v, input bit s, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    int budget;
    vectors     = 0;
    miscompares = 0;
    m_cnt0      = 0;
    m_cnt1      = 0;
    reset       = 1'b1;
    drive(1'b1, 1'b0, 32'hDEAD_BEEF);
    out0_ready  = 1'b1;
    out1_ready  = 1'b1;
    #1;

    // Reset held two cycles with in_valid high: nothing accepted, outputs idle
    step();
    step();
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    #1;
    check("rst_in_ready_after", 32'(in_ready), 32'd1);
    check("rst_out0_data", out0_data, 32'h0);
    check("rst_out1_valid", 32'(out1_valid), 32'd0);

    // Basic routing, one cycle latency
    drive(1'b1, 1'b0, 32'hA000_0001);
    step();
    check("route0_valid", 32'(out0_valid), 32'd1);
    check("route0_data", out0_data, 32'hA000_0001);
    drive(1'b1, 1'b1, 32'hB000_0002);
    step();
    check("route1_data", out1_data, 32'hB000_0002);
    drive(1'b0, 1'b0, 32'h0);
    step();

    // Backpressure on out0: two fit, third refused, sel1 still accepted
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h0000_0C01);
    step();
    drive(1'b1, 1'b0, 32'h0000_0C02);
    step();
    drive(1'b1, 1'b0, 32'h0000_0C03);
    #1;
    check("bp_third_refused", 32'(in_ready), 32'd0);
    drive(1'b1, 1'b1, 32'h0000_0D01);
    #1;
    check("bp_sel1_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_sel1_data", out1_data, 32'h0000_0D01);

    // Full with simultaneous pop: pop happens, push refused, retried next cycle
    drive(1'b1, 1'b0, 32'h0000_0C03);
    out0_ready = 1'b1;
    #1;
    check("fullpop_ready", 32'(in_ready), 32'd0);
    step();
    check("fullpop_refused", 32'(last_acc), 32'd0);
    check("fullpop_head", out0_data, 32'h0000_0C02);
    step();
    check("fullpop_retry", 32'(last_acc), 32'd1);
    drive(1'b0, 1'b0, 32'h0);
    out1_ready = 1'b1;
    repeat (4) step();

    // Wrap: ten words on sel1 with a toggling consumer
    rx1_q.delete();
    for (int i = 1; i <= 10; i++) begin
      budget = 0;
      drive(1'b1, 1'b1, 32'(i));
      do begin
        out1_ready = ~out1_ready;
        step();
        budget++;
      end while (!last_acc && budget < 50);
      if (!last_acc) check("wrap_timeout", 32'd1, 32'd0);
    end
    drive(1'b0, 1'b0, 32'h0);
    out1_ready = 1'b1;
    repeat (4) step();
    check("wrap_count", 32'(rx1_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < rx1_q.size(); i++)
      check("wrap_order", rx1_q[i], 32'(i + 1));

    // Mid-operation reset discards buffered words
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h0000_E001);
    step();
    drive(1'b1, 1'b1, 32'h0000_E002);
    step();
    drive(1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("midrst_out0_valid", 32'(out0_valid), 32'd0);
    check("midrst_out1_data", out1_data, 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);

`ifdef DEMUX_ROUTER_COUNT_EN
    // Five pops on out0 only
    out0_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'(32'hF00 + i));
      step();
    end
    drive(1'b0, 1'b0, 32'h0);
    step();
    check("cnt0_five", cnt0, 32'd5);
    check("cnt1_zero", cnt1, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("cnt0_rst", cnt0, 32'd0);
    check("cnt1_rst", cnt1, 32'd0);
`endif

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 59) == 0);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom);
      out0_ready = 1'($urandom_range(0, 2) != 0);
      out1_ready = 1'($urandom_range(0, 1));
      step();
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
